fractal_sync_pair_node: RTL and testbench



---
 rtl/fractal_sync_pkg.sv | 26 ++
 rtl/fractal_sync_child_slot.sv | 64 ++++++
 rtl/fractal_sync_pair_node.sv | 144 ++++++++++++++
 tb/tb_fractal_sync_pair_node.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization tree nodes.
package fractal_sync_pkg;

  localparam int unsigned SyncLvlWidth = 4;
  localparam int unsigned SyncIdWidth  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StUpReq,
    StUpWait,
    StRsp
  } pair_node_state_e;

  typedef struct packed {
    logic [SyncLvlWidth-1:0] level;
    logic [SyncIdWidth-1:0]  id;
  } sync_req_t;

  typedef struct packed {
    logic [SyncLvlWidth-1:0] level;
    logic [SyncIdWidth-1:0]  id;
    logic                    error;
  } sync_rsp_t;

endpackage

// File: rtl/fractal_sync_child_slot.sv
// Per-child barrier slot: captures {level, id} on handshake and drives the registered ready.
module fractal_sync_child_slot #(
  parameter int unsigned LVL_WIDTH = 4,
  parameter int unsigned ID_WIDTH  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [LVL_WIDTH-1:0] req_level_i,
  input  logic [ID_WIDTH-1:0]  req_id_i,
  input  logic                 accept_i,
  input  logic                 clear_i,
  output logic                 req_ready_o,
  output logic                 hs_o,
  output logic                 occupied_o,
  output logic [LVL_WIDTH-1:0] level_o,
  output logic [ID_WIDTH-1:0]  id_o
);

  logic                 ready_q, ready_d;
  logic                 occ_q, occ_d;
  logic [LVL_WIDTH-1:0] level_q, level_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;

  assign hs_o = req_valid_i & ready_q;

  always_comb begin
    occ_d   = occ_q;
    level_d = level_q;
    id_d    = id_q;
    if (clear_i) begin
      occ_d   = 1'b0;
      level_d = '0;
      id_d    = '0;
    end else if (hs_o) begin
      occ_d   = 1'b1;
      level_d = req_level_i;
      id_d    = req_id_i;
    end
    // Ready is registered, so it is derived from the next-cycle occupancy.
    ready_d = accept_i & ~occ_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      occ_q   <= 1'b0;
      level_q <= '0;
      id_q    <= '0;
    end else begin
      ready_q <= ready_d;
      occ_q   <= occ_d;
      level_q <= level_d;
      id_q    <= id_d;
    end
  end

  assign req_ready_o = ready_q;
  assign occupied_o  = occ_q;
  // Present the arriving request when the slot is still empty so both can be compared at once.
  assign level_o     = occ_q ? level_q : req_level_i;
  assign id_o        = occ_q ? id_q : req_id_i;

endmodule

// File: rtl/fractal_sync_pair_node.sv
// Leaf node of the sync tree: merges two child barriers, resolves locally or forwards upward.
module fractal_sync_pair_node
  import fractal_sync_pkg::*;
#(
  parameter int unsigned LVL_WIDTH  = SyncLvlWidth,
  parameter int unsigned ID_WIDTH   = SyncIdWidth,
  parameter int unsigned NODE_LEVEL = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             req_valid_i,
  input  logic [2*LVL_WIDTH-1:0] req_level_i,
  input  logic [2*ID_WIDTH-1:0]  req_id_i,
  output logic [1:0]             req_ready_o,
  output logic [1:0]             rsp_valid_o,
  output logic [LVL_WIDTH-1:0]   rsp_level_o,
  output logic [ID_WIDTH-1:0]    rsp_id_o,
  output logic                   rsp_error_o,
  output logic                   up_req_valid_o,
  output logic [LVL_WIDTH-1:0]   up_req_level_o,
  output logic [ID_WIDTH-1:0]    up_req_id_o,
  input  logic                   up_req_ready_i,
  input  logic                   up_rsp_valid_i,
  input  logic [LVL_WIDTH-1:0]   up_rsp_level_i,
  input  logic [ID_WIDTH-1:0]    up_rsp_id_i,
  input  logic                   up_rsp_error_i
);

  localparam logic [LVL_WIDTH-1:0] NodeLvl = LVL_WIDTH'(NODE_LEVEL);

  pair_node_state_e state_q, state_d;

  logic [1:0]           hs, occ, present;
  logic                 accept, clear, err_d;
  logic [LVL_WIDTH-1:0] view_level [2];
  logic [ID_WIDTH-1:0]  view_id    [2];

  logic [1:0]           rsp_valid_q;
  logic [LVL_WIDTH-1:0] rsp_level_q;
  logic [ID_WIDTH-1:0]  rsp_id_q;
  logic                 rsp_error_q;
  logic                 up_req_valid_q;
  logic [LVL_WIDTH-1:0] up_req_level_q;
  logic [ID_WIDTH-1:0]  up_req_id_q;

  assign accept  = (state_d == StIdle) || (state_d == StWait);
  assign clear   = (state_q == StRsp);
  assign present = occ | hs;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    fractal_sync_child_slot #(
      .LVL_WIDTH (LVL_WIDTH),
      .ID_WIDTH  (ID_WIDTH)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i[g]),
      .req_level_i (req_level_i[g*LVL_WIDTH +: LVL_WIDTH]),
      .req_id_i    (req_id_i[g*ID_WIDTH +: ID_WIDTH]),
      .accept_i    (accept),
      .clear_i     (clear),
      .req_ready_o (req_ready_o[g]),
      .hs_o        (hs[g]),
      .occupied_o  (occ[g]),
      .level_o     (view_level[g]),
      .id_o        (view_id[g])
    );
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle, StWait: begin
        if (|hs) begin
          if (&present) begin
            if ((view_level[0] != view_level[1]) || (view_id[0] != view_id[1]) ||
                (view_level[0] == '0)) begin
              state_d = StRsp;
              err_d   = 1'b1;
            end else if (view_level[0] == NodeLvl) begin
              state_d = StRsp;
            end else if (view_level[0] > NodeLvl) begin
              state_d = StUpReq;
            end else begin
              state_d = StRsp;
              err_d   = 1'b1;
            end
          end else begin
            state_d = StWait;
          end
        end
      end
      StUpReq: begin
        if (up_req_ready_i) state_d = StUpWait;
      end
      StUpWait: begin
        if (up_rsp_valid_i) begin
          state_d = StRsp;
          err_d   = up_rsp_error_i | (up_rsp_id_i != view_id[0]) |
                    (up_rsp_level_i != view_level[0]);
        end
      end
      StRsp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      rsp_valid_q    <= '0;
      rsp_level_q    <= '0;
      rsp_id_q       <= '0;
      rsp_error_q    <= 1'b0;
      up_req_valid_q <= 1'b0;
      up_req_level_q <= '0;
      up_req_id_q    <= '0;
    end else begin
      state_q        <= state_d;
      rsp_valid_q    <= {2{state_d == StRsp}};
      up_req_valid_q <= (state_d == StUpReq);
      if (state_d == StRsp) begin
        rsp_level_q <= view_level[0];
        rsp_id_q    <= view_id[0];
        rsp_error_q <= err_d;
      end
      // Latch the merged request once on entry so it stays stable under backpressure.
      if ((state_d == StUpReq) && (state_q != StUpReq)) begin
        up_req_level_q <= view_level[0];
        up_req_id_q    <= view_id[0];
      end
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_level_o    = rsp_level_q;
  assign rsp_id_o       = rsp_id_q;
  assign rsp_error_o    = rsp_error_q;
  assign up_req_valid_o = up_req_valid_q;
  assign up_req_level_o = up_req_level_q;
  assign up_req_id_o    = up_req_id_q;

endmodule

// File: tb/tb_fractal_sync_pair_node.sv
// Directed and randomized barriers against a rule-level model of the pair node.
module tb_fractal_sync_pair_node;

  localparam int unsigned LW = 4;
  localparam int unsigned IW = 2;
  localparam int          NL = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [2*LW-1:0] req_level;
  logic [2*IW-1:0] req_id;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [LW-1:0] rsp_level;
  logic [IW-1:0] rsp_id;
  logic          rsp_error;
  logic          up_req_valid;
  logic [LW-1:0] up_req_level;
  logic [IW-1:0] up_req_id;
  logic          up_req_ready;
  logic          up_rsp_valid;
  logic [LW-1:0] up_rsp_level;
  logic [IW-1:0] up_rsp_id;
  logic          up_rsp_error;

  int checks  = 0;
  int errors  = 0;
  int up_seen = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (up_req_valid === 1'b1) up_seen++;

  fractal_sync_pair_node #(
    .LVL_WIDTH  (LW),
    .ID_WIDTH   (IW),
    .NODE_LEVEL (NL)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_level_i    (req_level),
    .req_id_i       (req_id),
    .req_ready_o    (req_ready),
    .rsp_valid_o    (rsp_valid),
    .rsp_level_o    (rsp_level),
    .rsp_id_o       (rsp_id),
    .rsp_error_o    (rsp_error),
    .up_req_valid_o (up_req_valid),
    .up_req_level_o (up_req_level),
    .up_req_id_o    (up_req_id),
    .up_req_ready_i (up_req_ready),
    .up_rsp_valid_i (up_rsp_valid),
    .up_rsp_level_i (up_rsp_level),
    .up_rsp_id_i    (up_rsp_id),
    .up_rsp_error_i (up_rsp_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0: resolved locally, 1: error response, 2: forwarded to the parent.
  function automatic int model_kind(input int l0, input int i0, input int l1, input int i1);
    if (l0 != l1 || i0 != i1 || l0 == 0) return 1;
    if (l0 == NL) return 0;
    if (l0 > NL) return 2;
    return 1;
  endfunction

  // order: 0 simultaneous, 1 child0 first, 2 child1 first; bp: cycles of parent backpressure;
  // pid: offset added to the id the parent returns (non-zero means wrong id).
  task automatic run_barrier(input string tag, input int l0, input int i0, input int l1,
                             input int i1, input int order, input int gap, input int bp,
                             input int perr, input int pid);
    int kind;
    int base_up;
    int exp_err;
    kind    = model_kind(l0, i0, l1, i1);
    base_up = up_seen;
    check({tag, ":idle_ready"}, 32'(req_ready), 32'(2'b11));
    req_level = {LW'(l1), LW'(l0)};
    req_id    = {IW'(i1), IW'(i0)};
    if (order != 0) begin
      req_valid = (order == 1) ? 2'b01 : 2'b10;
      tick();
      req_valid = 2'b00;
      check({tag, ":wait_ready"}, 32'(req_ready), (order == 1) ? 32'(2'b10) : 32'(2'b01));
      repeat (gap) tick();
      check({tag, ":wait_no_rsp"}, 32'(rsp_valid), 32'(2'b00));
      req_valid = (order == 1) ? 2'b10 : 2'b01;
    end else begin
      req_valid = 2'b11;
    end
    tick();
    req_valid = 2'b00;
    if (kind != 2) begin
      check({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(2'b11));
      check({tag, ":rsp_error"}, 32'(rsp_error), (kind == 1) ? 32'(1) : 32'(0));
      check({tag, ":rsp_ready"}, 32'(req_ready), 32'(2'b00));
      if (kind == 0) begin
        check({tag, ":rsp_level"}, 32'(rsp_level), 32'(l0));
        check({tag, ":rsp_id"}, 32'(rsp_id), 32'(i0));
      end
    end else begin
      check({tag, ":up_valid"}, 32'(up_req_valid), 32'(1));
      check({tag, ":up_level"}, 32'(up_req_level), 32'(l0));
      check({tag, ":up_id"}, 32'(up_req_id), 32'(i0));
      for (int k = 0; k < bp; k++) begin
        tick();
        check({tag, ":up_hold_valid"}, 32'(up_req_valid), 32'(1));
        check({tag, ":up_hold_level"}, 32'(up_req_level), 32'(l0));
        check({tag, ":up_hold_id"}, 32'(up_req_id), 32'(i0));
      end
      up_req_ready = 1'b1;
      tick();
      up_req_ready = 1'b0;
      check({tag, ":up_done"}, 32'(up_req_valid), 32'(0));
      for (int k = 0; k < 3; k++) begin
        check({tag, ":upwait_ready"}, 32'(req_ready), 32'(2'b00));
        check({tag, ":upwait_no_rsp"}, 32'(rsp_valid), 32'(2'b00));
        tick();
      end
      up_rsp_valid = 1'b1;
      up_rsp_level = LW'(l0);
      up_rsp_id    = IW'((i0 + pid) % 4);
      up_rsp_error = (perr != 0);
      tick();
      up_rsp_valid = 1'b0;
      up_rsp_error = 1'b0;
      exp_err = (perr != 0 || (pid % 4) != 0) ? 1 : 0;
      check({tag, ":up_rsp_valid"}, 32'(rsp_valid), 32'(2'b11));
      check({tag, ":up_rsp_error"}, 32'(rsp_error), 32'(exp_err));
      check({tag, ":up_rsp_level"}, 32'(rsp_level), 32'(l0));
      check({tag, ":up_rsp_id"}, 32'(rsp_id), 32'(i0));
    end
    tick();
    check({tag, ":pulse_end"}, 32'(rsp_valid), 32'(2'b00));
    check({tag, ":reopen_ready"}, 32'(req_ready), 32'(2'b11));
    if (kind == 0) check({tag, ":rsp_hold"}, 32'(rsp_level), 32'(l0));
    check({tag, ":up_count"}, 32'(up_seen - base_up), (kind == 2) ? 32'(bp + 1) : 32'(0));
  endtask

  initial begin
    int l0, i0, l1, i1;
    rst          = 1'b1;
    req_valid    = 2'b00;
    req_level    = '0;
    req_id       = '0;
    up_req_ready = 1'b0;
    up_rsp_valid = 1'b0;
    up_rsp_level = '0;
    up_rsp_id    = '0;
    up_rsp_error = 1'b0;

    tick();
    tick();
    check("rst:ready", 32'(req_ready), 32'(2'b00));
    check("rst:rsp_valid", 32'(rsp_valid), 32'(2'b00));
    check("rst:up_valid", 32'(up_req_valid), 32'(0));
    check("rst:fields", 32'({rsp_level, rsp_id, rsp_error, up_req_level, up_req_id}), 32'(0));
    rst = 1'b0;
    tick();
    check("rst:release_ready", 32'(req_ready), 32'(2'b11));
    repeat (3) tick();

    run_barrier("local", 1, 2, 1, 2, 1, 3, 0, 0, 0);
    run_barrier("upward", 3, 1, 3, 1, 0, 0, 3, 0, 0);
    run_barrier("mismatch", 1, 0, 1, 3, 0, 0, 0, 0, 0);
    run_barrier("level0", 0, 1, 0, 1, 2, 1, 0, 0, 0);
    run_barrier("lvl_diff", 2, 1, 3, 1, 1, 0, 0, 0, 0);
    run_barrier("parent_err", 2, 1, 2, 1, 0, 0, 0, 1, 0);
    run_barrier("wrong_id", 2, 1, 2, 1, 2, 2, 1, 0, 1);

    // Reset while a forwarded barrier waits for its parent.
    req_level = {LW'(3), LW'(3)};
    req_id    = {IW'(2), IW'(2)};
    req_valid = 2'b11;
    tick();
    req_valid    = 2'b10;
    up_req_ready = 1'b1;
    tick();
    up_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp:upwait_ready", 32'(req_ready), 32'(2'b00));
      tick();
    end
    rst       = 1'b1;
    req_valid = 2'b00;
    tick();
    check("bp:rst_rsp", 32'(rsp_valid), 32'(2'b00));
    check("bp:rst_up", 32'(up_req_valid), 32'(0));
    check("bp:rst_ready", 32'(req_ready), 32'(2'b00));
    rst = 1'b0;
    tick();
    check("bp:release_ready", 32'(req_ready), 32'(2'b11));
    up_rsp_valid = 1'b1;
    up_rsp_level = LW'(3);
    up_rsp_id    = IW'(2);
    tick();
    up_rsp_valid = 1'b0;
    check("bp:late_rsp_ignored", 32'(rsp_valid), 32'(2'b00));
    check("bp:late_ready", 32'(req_ready), 32'(2'b11));
    tick();
    check("bp:still_no_rsp", 32'(rsp_valid), 32'(2'b00));
    run_barrier("post_reset", 1, 3, 1, 3, 0, 0, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      l0 = int'($urandom_range(0, 3));
      i0 = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        l1 = l0;
        i1 = i0;
      end else begin
        l1 = int'($urandom_range(0, 3));
        i1 = int'($urandom_range(0, 3));
      end
      run_barrier($sformatf("rand%0d", n), l0, i0, l1, i1, int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
